// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store sequencer with
// alignment checking, lane steering and a bounded memory wait.
module load_store_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    input  logic        req_is_store,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
    state_t state;
    logic [7:0] cnt;
    logic [2:0] f3;
    logic [1:0] lo;
    logic illegal;
    logic [3:0] be;
    logic [31:0] wdata, ld_data;
    logic [15:0] lane;
    assign req_ready = state == IDLE;
    always_comb begin
        illegal = (req_is_store ? (req_funct3[2] | &req_funct3[1:0])
                                : (&req_funct3[1:0] | &req_funct3[2:1]))
                | (req_funct3[1:0] == 2'b01 & req_addr[0])
                | (req_funct3[1:0] == 2'b10 & |req_addr[1:0]);
        be = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0]
           : req_funct3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}}
              : req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        // funct3[2] marks the unsigned variants, so it suppresses sign fill
        lane = 16'(mem_rdata >> {lo, 3'b000});
        ld_data = f3[1] ? mem_rdata
                : f3[0] ? {{16{~f3[2] & lane[15]}}, lane[15:0]}
                        : {{24{~f3[2] & lane[7]}}, lane[7:0]};
    end
    always_ff @(posedge clk) begin
        resp_valid <= 1'b0;
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            cnt        <= '0;
            f3         <= '0;
            lo         <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    f3 <= req_funct3;
                    lo <= req_addr[1:0];
                    if (illegal) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state     <= MEM;
                        mem_req   <= 1'b1;
                        mem_we    <= req_is_store;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= be;
                        mem_wdata <= wdata;
                        cnt       <= '0;
                    end
                end
                MEM: if (mem_ack) begin
                    state      <= RESP;
                    mem_req    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= mem_we ? '0 : ld_data;
                end else if (cnt == LAST) begin
                    state      <= RESP;
                    mem_req    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b1;
                    resp_rdata <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: transaction-level model of the load/store unit checked
// every cycle, plus directed scenarios with literal expectations.
module tb_load_store_unit;
    localparam int MW = 4;
    logic        clk = 0, reset = 1, req_valid = 0, req_is_store = 0, mem_ack = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic [2:0]  req_funct3 = 0;
    logic        req_ready, mem_req, mem_we, resp_valid, resp_error;
    logic [31:0] mem_addr, mem_wdata, resp_rdata;
    logic [3:0]  mem_be;

    load_store_unit #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .req_is_store(req_is_store), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    always #5 clk = ~clk;

    int cyc = 0, total = 0, bad = 0;
    int ta = -100, tk = 0;
    bit en = 0;
    logic        t_st = 0;
    logic [2:0]  t_f3 = 0;
    logic [31:0] t_addr = 0, t_wdata = 0, exp_rd = 0;
    logic        exp_er = 0;
    int          obs_mreq = 0, obs_rn = -1, n;
    logic [31:0] obs_addr = 0, obs_wdata = 0, obs_rd = 0;
    logic [3:0]  obs_be = 0;
    logic        obs_we = 0, obs_er = 0, x_mreq, x_rv, x_rdy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    function automatic bit is_ill(logic st, logic [2:0] f3, logic [31:0] a);
        int nb = 1 << f3[1:0];
        bit okf = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !okf || (a % nb != 0);
    endfunction

    function automatic logic [3:0] be_of(logic [2:0] f3, logic [31:0] a);
        int nb = 1 << f3[1:0];
        return 4'(((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wd_of(logic [2:0] f3, logic [31:0] w);
        int nb = 1 << f3[1:0];
        return nb == 1 ? 32'(w[7:0]) * 32'h01010101
             : nb == 2 ? 32'(w[15:0]) * 32'h00010001 : w;
    endfunction

    function automatic logic [31:0] ld_of(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        int nb = 1 << f3[1:0];
        longint v;
        if (nb == 4) return rd;
        v = longint'((64'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * nb)) - 64'd1));
        if (!f3[2] && v >= longint'(64'd1 << (8 * nb - 1))) v = v - longint'(64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // expected behaviour derived from the current transaction's acceptance cycle ta and length tk
    always @(negedge clk) if (en) begin
        n = cyc;
        x_mreq = n >= ta && n < ta + tk;
        x_rv = n == ta + tk;
        x_rdy = !(n >= ta && n <= ta + tk);
        chk("req_ready", 32'(req_ready), 32'(x_rdy));
        chk("mem_req", 32'(mem_req), 32'(x_mreq));
        chk("resp_valid", 32'(resp_valid), 32'(x_rv));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_error", 32'(resp_error), 32'(exp_er));
        if (x_mreq) begin
            chk("mem_addr", mem_addr, {t_addr[31:2], 2'b00});
            chk("mem_we", 32'(mem_we), 32'(t_st));
            chk("mem_be", 32'(mem_be), 32'(be_of(t_f3, t_addr)));
            if (t_st) chk("mem_wdata", mem_wdata, wd_of(t_f3, t_wdata));
        end
        if (mem_req) begin
            obs_mreq++;
            obs_addr = mem_addr;
            obs_wdata = mem_wdata;
            obs_be = mem_be;
            obs_we = mem_we;
        end
        if (resp_valid) begin
            obs_rn = n;
            obs_rd = resp_rdata;
            obs_er = resp_error;
        end
    end

    // issue one request now; memory acks after d wait cycles (d >= MW means timeout)
    task automatic do_tr(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] rd, input int d);
        bit ill, tmo;
        int k;
        logic [31:0] pend = 0;
        ill = is_ill(st, f3, a);
        tmo = !ill && d > MW - 1;
        k = ill ? 0 : (tmo ? MW : d + 1);
        t_st = st; t_f3 = f3; t_addr = a; t_wdata = w;
        obs_mreq = 0; obs_rn = -1;
        req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = w;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        ta = cyc + 1; tk = k;
        for (int j = 0; j <= k; j++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            req_funct3 = 3'($urandom); req_is_store = 1'($urandom);
            mem_rdata = $urandom;
            mem_ack = j < k ? (j == d) : 1'($urandom);
            if (j < k && j == d) begin
                mem_rdata = rd;
                pend = st ? 32'd0 : ld_of(f3, a, rd);
            end
            if (j == k) begin
                exp_rd = (ill || tmo) ? 32'd0 : pend;
                exp_er = ill || tmo;
            end
        end
        @(posedge clk); #1;
        req_valid = 0; mem_ack = 0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk); #1;
            req_valid = 0; mem_ack = 1'($urandom); mem_rdata = $urandom;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0] f;
        repeat (2) @(posedge clk);
        #1;
        en = 1;
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 0;

        do_tr(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
        chk("lw_addr", obs_addr, 32'h100);
        chk("lw_be", 32'(obs_be), 32'hF);
        chk("lw_latency", 32'(obs_rn - ta + 1), 2);
        chk("lw_rdata", obs_rd, 32'hDEADBEEF);
        chk("lw_error", 32'(obs_er), 0);

        do_tr(0, 3'b000, 32'h103, 0, 32'h80123456, 1);
        chk("lb_be", 32'(obs_be), 32'h8);
        chk("lb_rdata", obs_rd, 32'hFFFFFF80);
        do_tr(0, 3'b100, 32'h103, 0, 32'h80123456, 0);
        chk("lbu_rdata", obs_rd, 32'h00000080);

        do_tr(1, 3'b001, 32'h22, 32'h0000ABCD, $urandom, 2);
        chk("sh_we", 32'(obs_we), 1);
        chk("sh_addr", obs_addr, 32'h20);
        chk("sh_be", 32'(obs_be), 32'hC);
        chk("sh_wdata", obs_wdata, 32'hABCDABCD);
        chk("sh_rdata", obs_rd, 0);
        chk("sh_latency", 32'(obs_rn - ta + 1), 4);

        do_tr(0, 3'b010, 32'h102, 0, 0, 0);
        chk("lwmis_mreq", 32'(obs_mreq), 0);
        chk("lwmis_error", 32'(obs_er), 1);
        chk("lwmis_latency", 32'(obs_rn - ta + 1), 1);

        do_tr(0, 3'b010, 32'h200, 0, 0, MW + 3);
        chk("timeout_mreq", 32'(obs_mreq), MW);
        chk("timeout_error", 32'(obs_er), 1);
        do_tr(0, 3'b010, 32'h204, 0, 32'h12345678, MW - 1);
        chk("ackedge_mreq", 32'(obs_mreq), MW);
        chk("ackedge_error", 32'(obs_er), 0);
        chk("ackedge_rdata", obs_rd, 32'h12345678);

        // reset while the memory is still being waited on
        t_st = 0; t_f3 = 3'b010; t_addr = 32'h300; obs_rn = -1;
        req_valid = 1; req_is_store = 0; req_funct3 = 3'b010; req_addr = 32'h300; mem_ack = 0;
        ta = cyc + 1; tk = MW;
        @(posedge clk); #1; req_valid = 0; mem_ack = 0;
        @(posedge clk); #1; reset = 1;
        @(posedge clk); #1; reset = 0; mem_ack = 1;
        ta = -100; tk = 0; exp_rd = 0; exp_er = 0; obs_rn = -1;
        @(posedge clk); #1; mem_ack = 0;
        chk("rstm_mem_req", 32'(mem_req), 0);
        chk("rstm_mem_we", 32'(mem_we), 0);
        chk("rstm_mem_addr", mem_addr, 0);
        chk("rstm_mem_wdata", mem_wdata, 0);
        chk("rstm_mem_be", 32'(mem_be), 0);
        chk("rstm_resp_valid", 32'(resp_valid), 0);
        chk("rstm_ready", 32'(req_ready), 1);
        chk("rstm_no_resp", 32'(obs_rn), 32'hFFFFFFFF);

        for (int i = 0; i < 300; i++) begin
            f = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f[1:0]) - 32'd1);
            do_tr(1'($urandom), f, a, $urandom, $urandom, $urandom_range(0, MW + 1));
            idle($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
